// File: rtl/diff_core_pkg.sv
// rtl/diff_core_pkg.sv - shared datapath constants and types for the diff core
package diff_core_pkg;

  localparam int PSUM_WIDTH = 32;

  typedef logic [PSUM_WIDTH-1:0] psum_t;

endpackage

// File: rtl/psum_adder.sv
// rtl/psum_adder.sv - modulo-wrap partial-sum adder
module psum_adder
  import diff_core_pkg::*;
(
  input  psum_t a,
  input  psum_t b,
  output psum_t sum
);

  // Carry out is dropped on purpose: psums wrap at PSUM_WIDTH.
  assign sum = a + b;

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts at ptr
module rr_arbiter #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         any
);

  localparam logic [W:0] N_EXT = (W+1)'(N);

  logic [W:0] cand;

  // One extra bit on cand so ptr + offset can exceed N-1 before the wrap.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr} + (W+1)'(i);
      if (cand >= N_EXT) begin
        cand = cand - N_EXT;
      end
      if (!any && req[cand[W-1:0]]) begin
        any               = 1'b1;
        gnt_idx           = cand[W-1:0];
        gnt[cand[W-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/psum_add_arbiter.sv
// rtl/psum_add_arbiter.sv - round-robin sharing of one psum adder with a registered result slot
module psum_add_arbiter
  import diff_core_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int SRC_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  psum_t [N_REQ-1:0]      req_a,
  input  psum_t [N_REQ-1:0]      req_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output psum_t                  out_sum,
  output logic [SRC_W-1:0]       out_src,
  output logic                   out_ovf
);

  logic             slot_free;
  logic             xfer;
  logic             any;
  logic [N_REQ-1:0] gnt;
  logic [SRC_W-1:0] gnt_idx;
  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] ptr_next;
  psum_t            a_sel;
  psum_t            b_sel;
  psum_t            sum;
  logic             ovf;

  assign slot_free = !out_valid || out_ready;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  // Grant is offered only when the slot can take the result this edge.
  assign req_ready = (slot_free && !rst) ? gnt : '0;
  assign xfer      = any && slot_free && !rst;

  assign a_sel = req_a[gnt_idx];
  assign b_sel = req_b[gnt_idx];

  psum_adder u_add (
    .a   (a_sel),
    .b   (b_sel),
    .sum (sum)
  );

  assign ovf = (a_sel[PSUM_WIDTH-1] == b_sel[PSUM_WIDTH-1]) &&
               (sum[PSUM_WIDTH-1] != a_sel[PSUM_WIDTH-1]);

  assign ptr_next = (gnt_idx == SRC_W'(N_REQ-1)) ? '0 : gnt_idx + SRC_W'(1);

  // A drain and a new transfer on the same edge simply overwrite the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_src   <= '0;
      out_ovf   <= 1'b0;
      rr_ptr    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_sum   <= sum;
      out_src   <= gnt_idx;
      out_ovf   <= ovf;
      rr_ptr    <= ptr_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_psum_add_arbiter.sv
// tb/tb_psum_add_arbiter.sv - vector table plus result scoreboard for psum_add_arbiter
module tb_psum_add_arbiter;
  import diff_core_pkg::*;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_ready;
  psum_t [N-1:0] req_a;
  psum_t [N-1:0] req_b;
  logic         out_valid;
  logic         out_ready;
  psum_t        out_sum;
  logic [1:0]   out_src;
  logic         out_ovf;

  typedef struct {
    logic [N-1:0] valid;
    logic         ordy;
    logic [N-1:0] exp_rdy;
    psum_t        a;
    psum_t        b;
  } vec_t;

  typedef struct {
    psum_t      sum;
    logic [1:0] src;
    logic       ovf;
  } res_t;

  vec_t vecs[$];
  res_t sb[$];
  int   checks = 0;
  int   failures = 0;

  psum_add_arbiter #(.N_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_src   (out_src),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int oh_idx(logic [N-1:0] x);
    int r = 0;
    for (int i = 0; i < N; i++) if (x[i]) r = i;
    return r;
  endfunction

  function automatic res_t model(psum_t a, psum_t b, int src);
    res_t   r;
    longint sa, sb_, s;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    s  = sa + sb_;
    r.sum = s[31:0];
    r.src = 2'(src);
    r.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return r;
  endfunction

  function automatic void add(logic [N-1:0] valid, logic ordy, logic [N-1:0] exp_rdy,
                              psum_t a, psum_t b);
    vec_t v;
    v.valid = valid; v.ordy = ordy; v.exp_rdy = exp_rdy; v.a = a; v.b = b;
    vecs.push_back(v);
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic apply(vec_t v, string tag);
    int g;
    g = oh_idx(v.exp_rdy);
    req_valid = v.valid;
    out_ready = v.ordy;
    for (int i = 0; i < N; i++) begin
      req_a[i] = v.a + 32'(i * 1000 + 17);
      req_b[i] = v.b + 32'(i * 77 + 3);
    end
    if (v.exp_rdy != '0) begin
      req_a[g] = v.a;
      req_b[g] = v.b;
    end
    #2;
    check({tag, "_ready"}, req_ready, v.exp_rdy);
    check({tag, "_valid"}, out_valid, sb.size() > 0);
    if (sb.size() > 0) begin
      check({tag, "_sum"}, out_sum, sb[0].sum);
      check({tag, "_src"}, out_src, sb[0].src);
      check({tag, "_ovf"}, out_ovf, sb[0].ovf);
      if (v.ordy) void'(sb.pop_front());
    end
    if (v.exp_rdy != '0) sb.push_back(model(v.a, v.b, g));
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // single request, then overflow/wrap cases steering rr_ptr back to 0
    add(4'b0001, 1, 4'b0001, 32'd5, 32'd7);
    add(4'b0000, 1, 4'b0000, 0, 0);
    add(4'b0000, 1, 4'b0000, 0, 0);
    add(4'b0010, 1, 4'b0010, 32'h7FFF_FFFF, 32'h1);
    add(4'b0100, 1, 4'b0100, 32'hFFFF_FFFF, 32'h1);
    add(4'b1000, 1, 4'b1000, 32'h8000_0000, 32'h8000_0000);
    // fairness: 0,1,2,3,0,1,2,3
    for (int k = 0; k < 8; k++)
      add(4'b1111, 1, 4'(1 << (k % 4)), 32'(k * 11 + 1), 32'(k * 5 + 2));
    // backpressure with slot full
    for (int k = 0; k < 3; k++) add(4'b0110, 0, 4'b0000, 32'd9, 32'd9);
    add(4'b0110, 1, 4'b0010, 32'd100, 32'd23);
    add(4'b0000, 1, 4'b0000, 0, 0);
    add(4'b0000, 1, 4'b0000, 0, 0);
    // pointer wrap/skip from rr_ptr=3
    add(4'b0100, 1, 4'b0100, 32'd1, 32'd2);
    add(4'b0101, 1, 4'b0001, 32'hFFFF_FFF0, 32'h20);
    add(4'b0101, 1, 4'b0100, 32'h8000_0000, 32'hFFFF_FFFF);
    add(4'b0000, 1, 4'b0000, 0, 0);
    add(4'b0001, 0, 4'b0001, 32'd40, 32'd2);

    rst = 1'b1;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    req_a = '0;
    req_b = '0;
    #2;
    check("rst_ready", req_ready, 4'b0000);
    check("rst_valid", out_valid, 1'b0);
    check("rst_sum", out_sum, 32'd0);
    check("rst_src", out_src, 2'd0);
    check("rst_ovf", out_ovf, 1'b0);
    @(negedge clk);
    req_valid = '0;
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

    // asynchronous reset mid-cycle with the slot full
    req_valid = 4'b1111;
    out_ready = 1'b0;
    #1;
    check("pre_rst_valid", out_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_ready", req_ready, 4'b0000);
    check("mid_rst_sum", out_sum, 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    begin
      vec_t v;
      v.valid = 4'b0000; v.ordy = 1; v.exp_rdy = 4'b0000; v.a = 0; v.b = 0;
      apply(v, "post_rst0");
      apply(v, "post_rst1");
      v.valid = 4'b1111; v.exp_rdy = 4'b0001; v.a = 32'd3; v.b = 32'd4;
      apply(v, "post_rst_ptr");
      v.valid = 4'b0000; v.exp_rdy = 4'b0000;
      apply(v, "post_rst_drain");
      apply(v, "post_rst_idle");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/psum_add_arbiter.md
Name: psum_add_arbiter

Overview:
- Shares one PSUM adder (sum = a + b, PSUM_WIDTH bits, modulo wrap) between N_REQ requesters, e.g. PE rows returning partial sums for accumulation.
- Round-robin arbitration on valid/ready request ports.
- One registered result slot with valid/ready backpressure toward the psum buffer writer.
- Sits between the PE array outputs and the psum buffer; instantiates the shared adder.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- SRC_W, $clog2(N_REQ), width of source id (derived localparam, not overridable).
- PSUM_WIDTH, from diff_core_pkg, operand/result width (package constant, not a module parameter).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester operand valid.
- req_ready  out  N_REQ  per-requester accept (one-hot or zero).
- req_a  in  N_REQ x PSUM_WIDTH  operand a per requester.
- req_b  in  N_REQ x PSUM_WIDTH  operand b per requester.
- out_valid  out  1  result slot full.
- out_ready  in  1  downstream accepts result.
- out_sum  out  PSUM_WIDTH  registered a + b.
- out_src  out  SRC_W  index of requester that produced out_sum.
- out_ovf  out  1  signed overflow of that addition (two's complement).

Behaviour:
Reset values:
- rst high: out_valid=0, out_sum=0, out_src=0, out_ovf=0, rr_ptr=0.
- req_ready is combinational and forced to 0 while rst is high.

Arbitration:
- slot_free = !out_valid || out_ready.
- When slot_free, grant the first requester with req_valid=1, searching from rr_ptr upward with wrap at N_REQ-1 -> 0.
- req_ready[g]=1 for the grantee only; all other bits 0.
- When no slot_free, req_ready is all 0.
- req_ready depends on req_valid (combinational grant). Requesters must not make req_valid depend on req_ready.

Transfer and datapath:
- Transfer occurs when req_valid[g] && req_ready[g].
- The muxed operands feed the shared adder combinationally. On the same edge, register out_sum=a+b (low PSUM_WIDTH bits, carry dropped), out_src=g, out_ovf=(a[msb]==b[msb]) && (sum[msb]!=a[msb]), and set out_valid=1.
- Latency: 1 cycle from transfer to out_valid.
- Throughput: 1 result per cycle while out_ready=1.

Pointer update:
- After a transfer, rr_ptr = g+1 mod N_REQ.
- Without a transfer, rr_ptr holds.

Output handshake:
- Simultaneous drain and new transfer in the same cycle: the slot is overwritten with the new result and out_valid stays 1.
- Drain without a new transfer: out_valid goes to 0. out_sum/out_src/out_ovf hold their last values (don't-care).
- out_valid=1 && out_ready=0: out_* hold stable, req_ready is all 0, and no requester is starved of fairness (rr_ptr is unchanged).

Fairness:
- With all requesters continuously valid, each is granted exactly once every N_REQ transfers.

Reset mid-operation:
- Asynchronous clear of the pending result. The in-flight result is lost.
- The requester whose transfer completed is not re-offered; upstream is responsible for any retry.

Arithmetic corner cases:
- 0x7FFF_FFFF + 1 gives 0x8000_0000 with ovf=1.
- 0xFFFF_FFFF + 1 gives 0 with ovf=0 (unsigned wrap).

Decomposition:
- diff_core_pkg: PSUM_WIDTH (existing); add typedef psum_t = logic [PSUM_WIDTH-1:0].
- Sub-module rr_arbiter (parameter N): inputs req, ptr; outputs one-hot gnt, gnt_idx, any. Reusable for other shared resources.
- Existing adder instantiated once for the sum. Overflow logic stays local.

Test Plan (PSUM_WIDTH=32, N_REQ=4):
- Reset/idle: assert rst asynchronously mid-cycle with out_valid=1 -> out_valid=0 and req_ready=0 immediately; after release with no req_valid, out_valid stays 0.
- Single request: req_valid=0001, a=5, b=7 -> req_ready=0001 same cycle; next cycle out_valid=1, out_sum=12, out_src=0, out_ovf=0.
- Fairness: req_valid=1111 held, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3; each req_ready pulses once per 4 cycles.
- Backpressure: fill slot, out_ready=0 for 3 cycles with req_valid=0110 -> req_ready=0000, out_* stable; raise out_ready -> same-cycle grant to 1, next result out_src=1.
- Overflow/wrap: a=0x7FFFFFFF, b=1 -> out_sum=0x80000000, out_ovf=1. a=0xFFFFFFFF, b=1 -> out_sum=0, out_ovf=0. a=0x80000000, b=0x80000000 -> out_sum=0, out_ovf=1.
- Pointer wrap/skip: rr_ptr=3, req_valid=0101 -> grant 0, then grant 2 on the next free cycle.
